con_ser_emulator: RTL and testbench

- Generic console-controller emulator: captures a parallel button word and shifts it out serially to a NES/SNES-style console on latch/clock requests.
- Generalises the fixed 8- and 12-button serialisers: button count and frame length are parameters, and console strobes are synchronised into one system clock domain instead of clocking logic directly from the console.
- Sits between the button receivers and the console connector; one instance per console port.

---
 rtl/con_ser_pkg.sv | 23 ++
 rtl/con_sync_edge.sv | 44 ++++
 rtl/con_ser_emulator.sv | 182 ++++++++++++++++++
 tb/tb_con_ser_emulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/con_ser_pkg.sv
// con_ser_pkg: shared types and constants for the console serialiser emulator.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package con_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Common frame lengths.
  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // bit_idx has to hold 0..total_bits inclusive. It reaches total_bits at
  // end of frame.
  function automatic int idx_width(input int total_bits);
    return $clog2(total_bits + 1);
  endfunction

endpackage

// File: rtl/con_sync_edge.sv
// con_sync_edge: multi-flop synchroniser for one asynchronous strobe, with
// registered rise/fall pulses.
// Latency: pin edge to level/rise/fall outputs = STAGES+1 clk cycles.
// Backpressure: none. Pulses are single-cycle and unconditional.
//
// Ports:
//   clk, reset : system clock and synchronous active-high reset
//   din        : asynchronous input pin
//   level      : synchronised level, aligned with the pulses
//   rise, fall : one-cycle pulses on a synchronised 0->1 / 1->0 transition
module con_sync_edge
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
)
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // 'level' is the previous-sample flop of the edge detector. It updates
  // on the same edge as the pulses, so the FSM sees a consistent view of
  // level and edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/con_ser_emulator.sv
// con_ser_emulator: captures a parallel button word and shifts it out
// serially (active-low) to a NES/SNES-style console on latch/clock strobes.
// Latency: strobe pin edge to output change = SYNC_STAGES+2 clk cycles.
// Backpressure: none. The console paces the frame, and strobes are never stalled.
//
// Ports:
//   clk, reset  : system clock and synchronous active-high reset
//   buttons     : 1 = pressed, bit i is serial slot i
//   turbo_mask  : 1 = slot auto-toggles per frame (only with CON_SER_TURBO_EN)
//   con_latch   : console latch (async)
//   con_clock   : console data clock (async, idle high)
//   con_data    : serial data to console, 0 = pressed
//   busy        : high in LOAD or SHIFT
//   frame_done  : one-cycle pulse when the last slot has been clocked out
//   bit_idx     : slot currently presented
//
// Optional feature: define CON_SER_TURBO_EN to enable per-slot turbo.
module con_ser_emulator
  import con_ser_pkg::*;
#(
  parameter int N_BUTTONS   = 12,
  parameter int TOTAL_BITS  = 16,
  parameter int SYNC_STAGES = 2
)
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_BUTTONS-1:0]                buttons,
  input  logic [N_BUTTONS-1:0]                turbo_mask,
  input  logic                                con_latch,
  input  logic                                con_clock,
  output logic                                con_data,
  output logic                                busy,
  output logic                                frame_done,
  output logic [idx_width(TOTAL_BITS)-1:0]    bit_idx
);

  localparam int             IDX_W    = idx_width(TOTAL_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BITS - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(TOTAL_BITS);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;

  con_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (con_latch),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  // The console clock idles high, so its synchroniser resets to 1. This
  // keeps the reset release from producing a false edge.
  con_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_clock_sync (
    .clk   (clk),
    .reset (reset),
    .din   (con_clock),
    .level (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Only rising edges of the data clock matter.
  logic unused_clk_sync;
  assign unused_clk_sync = clk_lvl ^ clk_fall;

  state_t                state;
  logic [TOTAL_BITS-1:0] sreg;
  logic [TOTAL_BITS-1:0] load_val;
  logic [TOTAL_BITS-1:0] shifted;
  logic                  go_load;
  logic                  enter_load;

  // A latch rise restarts the frame from any state. A latch that is
  // already high also (re)starts from IDLE/DONE, for example when it was
  // high while reset was released.
  assign go_load    = latch_rise || (latch_lvl && (state == IDLE || state == DONE));
  assign enter_load = go_load && (state != LOAD);

`ifdef CON_SER_TURBO_EN
  logic parity;
  logic turbo_phase;

  // parity toggles as LOAD is entered. The frame being loaded uses the
  // phase it entered with. On the entry cycle that is still in the flop,
  // and once in LOAD it is the complement of the flop. So the first frame
  // after reset is loaded unmasked, and frames then alternate.
  assign turbo_phase = (state == LOAD) ? ~parity : parity;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (enter_load) begin
      parity <= ~parity;
    end
  end
`else
  logic unused_turbo;
  assign unused_turbo = (^turbo_mask) ^ enter_load;
`endif

  // Serial word is active-low. Slots above N_BUTTONS report released (1).
  always_comb begin
    load_val = '1;
    for (int i = 0; i < N_BUTTONS; i++) begin
`ifdef CON_SER_TURBO_EN
      load_val[i] = ~(buttons[i] & ~(turbo_mask[i] & turbo_phase));
`else
      load_val[i] = ~buttons[i];
`endif
    end
  end

  always_comb begin
    shifted                 = sreg >> 1;
    shifted[TOTAL_BITS-1]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '1;
      con_data   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (go_load) begin
        // Latch takes priority over any clock edge detected in the same
        // cycle. A partial frame is dropped without frame_done.
        state    <= LOAD;
        busy     <= 1'b1;
        bit_idx  <= '0;
        sreg     <= load_val;
        con_data <= load_val[0];
      end else begin
        case (state)
          LOAD: begin
            if (latch_fall) begin
              // Freeze the word captured on the previous cycle.
              state <= SHIFT;
            end else begin
              sreg     <= load_val;
              con_data <= load_val[0];
            end
          end
          SHIFT: begin
            if (clk_rise && !latch_lvl) begin
              if (bit_idx == LAST_IDX) begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                con_data   <= 1'b1;
                bit_idx    <= END_IDX;
              end else begin
                bit_idx  <= bit_idx + 1'b1;
                sreg     <= shifted;
                con_data <= shifted[0];
              end
            end
          end
          DONE: begin
            con_data <= 1'b1;
          end
          default: begin
            con_data <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_con_ser_emulator.sv
module tb_con_ser_emulator;
  import con_ser_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic con_latch;
  logic con_clock;

  logic [7:0]  buttons8;
  logic [7:0]  turbo8;
  logic [11:0] buttons16;
  logic [11:0] turbo16;

  logic       data8, busy8, done8;
  logic [3:0] idx8;
  logic       data16, busy16, done16;
  logic [4:0] idx16;

  int n_assert = 0;
  int n_fail   = 0;
  int fd8_cnt  = 0;
  int fd16_cnt = 0;

  logic [7:0]  exp8;
  logic [15:0] exp16;
  int          fd8_ref;
  int          fd16_ref;

  always #5 clk = ~clk;

  con_ser_emulator #(
    .N_BUTTONS   (8),
    .TOTAL_BITS  (NES_BITS),
    .SYNC_STAGES (2)
  ) dut8 (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons8),
    .turbo_mask (turbo8),
    .con_latch  (con_latch),
    .con_clock  (con_clock),
    .con_data   (data8),
    .busy       (busy8),
    .frame_done (done8),
    .bit_idx    (idx8)
  );

  con_ser_emulator #(
    .N_BUTTONS   (12),
    .TOTAL_BITS  (SNES_BITS),
    .SYNC_STAGES (2)
  ) dut16 (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons16),
    .turbo_mask (turbo16),
    .con_latch  (con_latch),
    .con_clock  (con_clock),
    .con_data   (data16),
    .busy       (busy16),
    .frame_done (done16),
    .bit_idx    (idx16)
  );

  always @(negedge clk) begin
    if (done8)  fd8_cnt++;
    if (done16) fd16_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Latch high long enough to settle in LOAD, then low. Returns with both
  // DUTs in SHIFT, presenting slot 0.
  task automatic latch_pulse();
    con_latch = 1'b1;
    cyc(6);
    con_latch = 1'b0;
    cyc(4);
  endtask

  // One console clock period. Returns once the rising edge has taken effect.
  task automatic clk_pulse();
    con_clock = 1'b0;
    cyc(4);
    con_clock = 1'b1;
    cyc(4);
  endtask

  initial begin
    reset     = 1'b1;
    con_latch = 1'b0;
    con_clock = 1'b1;
    buttons8  = 8'h00;
    buttons16 = 12'h000;
    turbo8    = 8'h00;
    turbo16   = 12'h000;
    cyc(3);

    // Reset state.
    chk("rst_data8",  32'(data8), 32'd1);
    chk("rst_busy8",  32'(busy8), 32'd0);
    chk("rst_done8",  32'(done8), 32'd0);
    chk("rst_idx8",   32'(idx8),  32'd0);
    chk("rst_data16", 32'(data16), 32'd1);
    chk("rst_busy16", 32'(busy16), 32'd0);
    reset = 1'b0;
    cyc(3);
    chk("idle_busy8", 32'(busy8), 32'd0);

    // Full frames: NES with 0000_0101, SNES with all 12 pressed.
    buttons8  = 8'b0000_0101;
    buttons16 = 12'hFFF;
    exp8      = 8'b1111_1010;
    exp16     = 16'hF000;
    con_latch = 1'b1;
    cyc(4);
    chk("load_busy8", 32'(busy8), 32'd1);
    chk("load_idx8",  32'(idx8),  32'd0);
    chk("load_data8", 32'(data8), 32'd0);
    cyc(2);
    con_latch = 1'b0;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("f1_data8_s%0d", i),  32'(data8),  32'(exp8[i]));
      chk($sformatf("f1_idx8_s%0d", i),   32'(idx8),   32'(i));
      chk($sformatf("f1_data16_s%0d", i), 32'(data16), 32'(exp16[i]));
      clk_pulse();
    end
    chk("f1_done8",     32'(done8), 32'd1);
    chk("f1_end_data8", 32'(data8), 32'd1);
    chk("f1_end_busy8", 32'(busy8), 32'd0);
    chk("f1_end_idx8",  32'(idx8),  32'd8);
    for (int i = 8; i < 16; i++) begin
      chk($sformatf("f1_data16_s%0d", i), 32'(data16), 32'(exp16[i]));
      chk($sformatf("f1_post_data8_%0d", i), 32'(data8), 32'd1);
      clk_pulse();
    end
    chk("f1_done16",     32'(done16), 32'd1);
    chk("f1_end_data16", 32'(data16), 32'd1);
    clk_pulse();
    chk("f1_extra_data16", 32'(data16), 32'd1);
    chk("f1_extra_done16", 32'(done16), 32'd0);
    chk("f1_fd8_count",    32'(fd8_cnt),  32'd1);
    chk("f1_fd16_count",   32'(fd16_cnt), 32'd1);

    // Latch re-asserted after 3 clocks: frame abandoned, new frame from slot 0.
    fd8_ref   = fd8_cnt;
    buttons8  = 8'h01;
    latch_pulse();
    chk("ab_s0_data8", 32'(data8), 32'd0);
    repeat (3) clk_pulse();
    chk("ab_idx8_3", 32'(idx8), 32'd3);
    buttons8  = 8'h02;
    con_latch = 1'b1;
    cyc(4);
    chk("ab_idx8_0",  32'(idx8),  32'd0);
    chk("ab_busy8",   32'(busy8), 32'd1);
    chk("ab_data8",   32'(data8), 32'd1);
    cyc(2);
    con_latch = 1'b0;
    cyc(4);
    chk("ab_new_s0", 32'(data8), 32'd1);
    clk_pulse();
    chk("ab_new_s1", 32'(data8), 32'd0);
    chk("ab_no_fd8", 32'(fd8_cnt), 32'(fd8_ref));

    // buttons change during SHIFT does not reach the frame in flight.
    buttons8 = 8'h01;
    latch_pulse();
    chk("chg_s0", 32'(data8), 32'd0);
    buttons8 = 8'h80;
    for (int i = 1; i < 8; i++) begin
      clk_pulse();
      chk($sformatf("chg_s%0d", i), 32'(data8), 32'd1);
    end
    chk("chg_idx7", 32'(idx8), 32'd7);
    clk_pulse();
    chk("chg_done8", 32'(done8), 32'd1);

    // Clock edges while latch is high are ignored.
    fd16_ref  = fd16_cnt;
    con_latch = 1'b1;
    cyc(4);
    clk_pulse();
    clk_pulse();
    chk("lh_idx8",  32'(idx8),  32'd0);
    chk("lh_busy8", 32'(busy8), 32'd1);
    chk("lh_idx16", 32'(idx16), 32'd0);
    con_latch = 1'b0;
    cyc(4);
    clk_pulse();
    clk_pulse();
    chk("lh_idx8_2", 32'(idx8), 32'd2);
    chk("lh_data8_s2", 32'(data8), 32'd1);

    // Reset mid-SHIFT.
    reset = 1'b1;
    cyc(1);
    chk("mr_data8", 32'(data8), 32'd1);
    chk("mr_busy8", 32'(busy8), 32'd0);
    chk("mr_idx8",  32'(idx8),  32'd0);
    chk("mr_done8", 32'(done8), 32'd0);
    chk("mr_busy16", 32'(busy16), 32'd0);
    reset = 1'b0;
    cyc(6);
    chk("mr_after_busy8", 32'(busy8), 32'd0);
    chk("mr_after_data8", 32'(data8), 32'd1);
    chk("mr_no_fd16", 32'(fd16_cnt), 32'(fd16_ref));

`ifdef CON_SER_TURBO_EN
    // Turbo on slot 0 with button 0 held: 0,1,0,1 over four frames.
    reset     = 1'b1;
    cyc(2);
    reset     = 1'b0;
    cyc(2);
    buttons16 = 12'h001;
    turbo16   = 12'h001;
    for (int f = 0; f < 4; f++) begin
      latch_pulse();
      chk($sformatf("turbo_f%0d", f), 32'(data16), 32'(f % 2));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
